// File: rtl/key_pkg.sv
// Shared types and constants for the key debounce slice.
package key_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 240000;

    // Smallest width w with 2**w > n, so a counter can hold every value 0..n.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((64'd1 << w) <= 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-flop synchroniser, debounce FSM with stability counter, registered outputs.
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cnt_width(DEFAULT_DEBOUNCE_CYCLES),
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_toggle
);

    localparam logic             IDLE_PIN = (KEY_ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             sync1_d, sync2_d;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             toggle_q, toggle_d;
    logic             act;

    // act = 1 means pressed regardless of board polarity.
    assign act = sync2_q ^ IDLE_PIN;

    always_comb begin
        sync1_d   = key_in;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        toggle_d  = toggle_q;
        case (state_q)
            ST_RELEASED: begin
                if (act) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!act) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = ST_PRESSED;
                    cnt_d    = '0;
                    level_d  = 1'b1;
                    press_d  = 1'b1;
                    toggle_d = ~toggle_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!act) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (act) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= IDLE_PIN;
            sync2_q   <= IDLE_PIN;
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_toggle  = toggle_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner: one independent debounce channel per key.
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cnt_width(DEFAULT_DEBOUNCE_CYCLES),
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_toggle
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .key_in     (key_in[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_toggle (key_toggle[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with 2 active-low keys and an 8-cycle debounce window.
module tb_key_debounce;

    logic       clk;
    logic       rst;
    logic [1:0] key_in;
    logic [1:0] key_level, key_press, key_release, key_toggle;

    int vec;
    int miss;
    int edge_n;
    int both_cnt;

    key_debounce #(
        .NUM_KEYS       (2),
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (4),
        .KEY_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_toggle (key_toggle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    initial both_cnt = 0;
    always @(negedge clk) if (|(key_press & key_release)) both_cnt <= both_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got edge %0d want finish", edge_n);
        $fatal(1, "watchdog");
    end

    // Returns at the falling edge following rising edge number e.
    task automatic wait_to(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        key_in = 2'b11;
        wait_to(2);
        vec++;
        if ({key_level, key_press, key_release, key_toggle} !== 8'h00) begin
            miss++;
            $display("FAIL reset_hold: outputs %h want 00", {key_level, key_press, key_release, key_toggle});
        end
        wait_to(5);
        rst = 1'b0;
        for (int e = 6; e <= 25; e++) begin
            wait_to(e);
            vec++;
            if ({key_level, key_press, key_release, key_toggle} !== 8'h00) begin
                miss++;
                $display("FAIL reset_idle edge %0d: outputs %h want 00", e, {key_level, key_press, key_release, key_toggle});
            end
        end
    endtask

    task automatic test_press_release_toggle;
        int b;
        b = edge_n;
        // key 0 pressed, first sampled at b+1; accepted at b+11
        key_in[0] = 1'b0;
        for (int e = b + 1; e <= b + 20; e++) begin
            wait_to(e);
            vec++;
            if (key_press !== {1'b0, (e == b + 11)} || key_level !== {1'b0, (e >= b + 11)} ||
                key_toggle !== {1'b0, (e >= b + 11)} || key_release !== 2'b00) begin
                miss++;
                $display("FAIL clean_press edge +%0d: press %b level %b toggle %b rel %b want press %b level/toggle %b",
                         e - b, key_press, key_level, key_toggle, key_release, (e == b + 11), (e >= b + 11));
            end
        end
        b = edge_n;
        key_in[0] = 1'b1;
        for (int e = b + 1; e <= b + 15; e++) begin
            wait_to(e);
            vec++;
            if (key_release !== {1'b0, (e == b + 11)} || key_level !== {1'b0, (e < b + 11)} ||
                key_toggle !== 2'b01 || key_press !== 2'b00) begin
                miss++;
                $display("FAIL release edge +%0d: rel %b level %b toggle %b press %b want rel %b level %b toggle 01",
                         e - b, key_release, key_level, key_toggle, key_press, (e == b + 11), (e < b + 11));
            end
        end
        b = edge_n;
        key_in[0] = 1'b0;
        for (int e = b + 1; e <= b + 14; e++) begin
            wait_to(e);
            vec++;
            if (key_press !== {1'b0, (e == b + 11)} || key_toggle !== {1'b0, (e < b + 11)}) begin
                miss++;
                $display("FAIL second_press edge +%0d: press %b toggle %b want press %b toggle %b",
                         e - b, key_press, key_toggle, (e == b + 11), (e < b + 11));
            end
        end
        key_in[0] = 1'b1;
        wait_to(edge_n + 14);
        vec++;
        if (key_level !== 2'b00 || key_toggle !== 2'b00) begin
            miss++;
            $display("FAIL after_second_release: level %b toggle %b want 00 00", key_level, key_toggle);
        end
    endtask

    task automatic test_bounce;
        int b;
        b = edge_n;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) key_in[0] = ~key_in[0];
            wait_to(b + i + 1);
            vec++;
            if (key_press !== 2'b00 || key_level !== 2'b00 || key_release !== 2'b00) begin
                miss++;
                $display("FAIL bounce i=%0d: press %b level %b rel %b want 00 00 00", i, key_press, key_level, key_release);
            end
        end
        key_in[0] = 1'b1;
        // 8-cycle low glitch: one short of the 9 sampled cycles needed to accept
        wait_to(edge_n + 12);
        b = edge_n;
        key_in[0] = 1'b0;
        wait_to(b + 8);
        key_in[0] = 1'b1;
        for (int e = b + 9; e <= b + 22; e++) begin
            wait_to(e);
            vec++;
            if (key_press !== 2'b00 || key_level !== 2'b00) begin
                miss++;
                $display("FAIL glitch8 edge +%0d: press %b level %b want 00 00", e - b, key_press, key_level);
            end
        end
    endtask

    task automatic test_independence;
        int b;
        b = edge_n;
        key_in[0] = 1'b0;
        wait_to(b + 3);
        key_in[1] = 1'b0;
        for (int e = b + 1; e <= b + 20; e++) begin
            wait_to(e);
            vec++;
            if (key_press !== {(e == b + 14), (e == b + 11)}) begin
                miss++;
                $display("FAIL independence edge +%0d: press %b want %b%b", e - b, key_press, (e == b + 14), (e == b + 11));
            end
        end
        vec++;
        if (key_level !== 2'b11 || key_toggle !== 2'b11) begin
            miss++;
            $display("FAIL independence_levels: level %b toggle %b want 11 11", key_level, key_toggle);
        end
        // simultaneous release of both keys must pulse both in the same cycle
        b = edge_n;
        key_in = 2'b11;
        for (int e = b + 1; e <= b + 14; e++) begin
            wait_to(e);
            vec++;
            if (key_release !== ((e == b + 11) ? 2'b11 : 2'b00)) begin
                miss++;
                $display("FAIL simultaneous_release edge +%0d: rel %b want %b", e - b, key_release, (e == b + 11) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        int b;
        b = edge_n;
        key_in[0] = 1'b0;
        wait_to(b + 5);
        rst = 1'b1;
        #1;
        vec++;
        if ({key_level, key_press, key_release, key_toggle} !== 8'h00) begin
            miss++;
            $display("FAIL rst_async_clear: outputs %h want 00", {key_level, key_press, key_release, key_toggle});
        end
        wait_to(b + 7);
        rst = 1'b0;
        for (int e = b + 8; e <= b + 20; e++) begin
            wait_to(e);
            vec++;
            if (key_press !== {1'b0, (e == b + 18)} || key_level !== {1'b0, (e >= b + 18)}) begin
                miss++;
                $display("FAIL rst_mid_wait edge +%0d: press %b level %b want press %b level %b",
                         e - b, key_press, key_level, (e == b + 18), (e >= b + 18));
            end
        end
        // reset while pressed: level and toggle clear, no release pulse ever follows
        rst = 1'b1;
        #1;
        vec++;
        if (key_level !== 2'b00 || key_toggle !== 2'b00 || key_release !== 2'b00) begin
            miss++;
            $display("FAIL rst_pressed: level %b toggle %b rel %b want 00 00 00", key_level, key_toggle, key_release);
        end
        key_in = 2'b11;
        wait_to(edge_n + 2);
        rst = 1'b0;
        b = edge_n;
        for (int e = b + 1; e <= b + 15; e++) begin
            wait_to(e);
            vec++;
            if (key_release !== 2'b00 || key_level !== 2'b00) begin
                miss++;
                $display("FAIL rst_pressed_after edge +%0d: rel %b level %b want 00 00", e - b, key_release, key_level);
            end
        end
    endtask

    task automatic test_exclusive;
        vec++;
        if (both_cnt !== 0) begin
            miss++;
            $display("FAIL press_release_overlap: %0d cycles want 0", both_cnt);
        end
    endtask

    initial begin
        vec    = 0;
        miss   = 0;
        rst    = 1'b1;
        key_in = 2'b11;
        test_reset;
        test_press_release_toggle;
        test_bounce;
        test_independence;
        test_reset_mid_wait;
        test_exclusive;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
